da_fir_ctrl: RTL and testbench
==============================

# da_fir_ctrl

Sequencer for the distributed-arithmetic FIR datapath. It accepts input samples over a valid/ready handshake and holds the ORDER-tap delay line. For each sample it steps through OPSIZE/BAAT bit-slices, driving the partitioned ROM address bus and the shift-accumulate controls. It sits between the sample source and the ROM/accumulator array of the DA FIR, one instance per filter.

## Interface

Parameters:
- OPSIZE, 12, sample width in bits (two's complement)
- ORDER, 6, number of taps
- BAAT, 3, bits processed per slice cycle
- PARTITION, 2, number of ROM partitions
- Derived: NSLICE = OPSIZE/BAAT (4); ADDR_W = ORDER/PARTITION (3); AW = PARTITION*BAAT*ADDR_W (18)
- Elaboration check: OPSIZE % BAAT == 0 and ORDER % PARTITION == 0, else fatal

Ports:
- clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_valid  in  1  input sample valid
- i_x  in  OPSIZE  input sample
- o_ready  out  1  sample accepted on the edge where i_valid && o_ready
- i_flush  in  1  clear delay line (honoured in IDLE only)
- o_rom_addr  out  AW  concatenated ROM addresses, field f = p*BAAT+j at [f*ADDR_W +: ADDR_W]
- o_acc_en  out  1  accumulator shift-add enable
- o_acc_clr  out  1  accumulator load (first slice) instead of add
- o_sign_slice  out  1  current slice holds sample MSB; accumulator subtracts MSB partial product
- o_slice  out  clog2(NSLICE)  current slice index
- o_done  out  1  one-cycle pulse: result complete in accumulator
- o_busy  out  1  state != IDLE

## Operation

- Delay line tap[0..ORDER-1], OPSIZE bits each; on accept: tap[0] <= i_x, tap[i] <= tap[i-1]; tap[ORDER-1] is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: o_ready = (state==IDLE) && !i_flush && i_rst_n. Accept → RUN, slice <= 0. i_flush=1 → all taps <= 0, stay IDLE. Flush wins over a simultaneous i_valid; the sample is not accepted.
  - RUN: o_acc_en=1, o_slice=slice. o_acc_clr=1 iff slice==0. o_sign_slice=1 iff slice==NSLICE-1. slice increments each cycle. At slice==NSLICE-1 → DONE.
  - DONE: o_done=1 for one cycle, then → IDLE.
- Address mapping in RUN, slice k, partition p, bit j, address bit m: o_rom_addr[(p*BAAT+j)*ADDR_W + m] = tap[p*ADDR_W+m][k*BAAT+j]. Slices run LSB first.
- Outside RUN: o_rom_addr, o_acc_en, o_acc_clr, o_sign_slice, o_slice are all 0.
- i_valid/i_x are ignored outside IDLE. The source must hold them until accepted. i_flush outside IDLE is ignored, not latched.
- Outputs depend only on state, slice and tap registers. There is no combinational path from i_valid/i_x to the outputs. The sole exception is i_flush → o_ready.

## Timing

- Reset (i_rst_n=0 at an edge): state IDLE, slice 0, all taps 0, o_done/o_acc_* /o_busy = 0, o_rom_addr = 0. o_ready = 0 while i_rst_n is low.
- Reset mid-RUN or mid-DONE: IDLE on the next cycle, taps cleared, no o_done pulse.
- Accept at edge E0. RUN during cycles E0+1 .. E0+NSLICE. o_done during cycle E0+NSLICE+1. o_ready high again at E0+NSLICE+2.
- Throughput: one sample per NSLICE+2 cycles (6 at defaults).
- The ROM is combinational. The accumulator registers on the same edge as o_acc_en. The result is valid in the accumulator during the o_done cycle.

## Test plan

- Reset: hold i_rst_n=0 for 3 cycles, then release → o_ready=0 during reset, 1 after release; o_busy=0; o_rom_addr=18'h0; o_done never asserted.
- Single sample: from a cleared line, push 12'hFFF → 4 RUN cycles with o_rom_addr=18'h00049 each. o_acc_clr on slice 0 only, o_sign_slice on slice 3 only, o_done one cycle after slice 3. o_ready=1 exactly 6 cycles after accept.
- Shift-through: push 12'h001 followed by five 12'h000 → after the sixth accept, slice 0 gives o_rom_addr=18'h00800 and slices 1–3 give 18'h0. A seventh push of 12'h000 gives 18'h0 on all slices.
- Backpressure: hold i_valid=1 continuously with incrementing i_x → exactly one accept per 6 cycles. o_ready=0 throughout RUN/DONE, and no sample is skipped or duplicated in tap[0] order.
- Flush collision: fill the line with 12'hFFF, then assert i_flush and i_valid together in IDLE → no accept that cycle. Accept 12'h000 the next cycle → o_rom_addr=0 on all slices.
- Reset mid-RUN: assert i_rst_n=0 at slice 2 → next cycle all outputs 0, state IDLE, no o_done. Next push of 12'hFFF gives 18'h00049, confirming the taps were cleared.

Source files
------------

// File: rtl/da_fir_ctrl.sv
// Sequencer for a distributed-arithmetic FIR: holds the tap delay line and walks
// each accepted sample through its bit-slices, driving ROM addresses and accumulator controls.
module da_fir_ctrl #(
  parameter int OPSIZE    = 12,
  parameter int ORDER     = 6,
  parameter int BAAT      = 3,
  parameter int PARTITION = 2,
  localparam int NSLICE   = OPSIZE / BAAT,
  localparam int ADDR_W   = ORDER / PARTITION,
  localparam int AW       = PARTITION * BAAT * ADDR_W,
  localparam int SLICE_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [OPSIZE-1:0]  i_x,
  output logic               o_ready,
  input  logic               i_flush,
  output logic [AW-1:0]      o_rom_addr,
  output logic               o_acc_en,
  output logic               o_acc_clr,
  output logic               o_sign_slice,
  output logic [SLICE_W-1:0] o_slice,
  output logic               o_done,
  output logic               o_busy
);

  localparam int BIT_W = (OPSIZE > 1) ? $clog2(OPSIZE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((OPSIZE % BAAT) != 0 || (ORDER % PARTITION) != 0) begin : gen_bad_params
    $fatal(1, "da_fir_ctrl: OPSIZE must be a multiple of BAAT and ORDER a multiple of PARTITION");
  end

  logic [1:0]         state_q, state_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic [OPSIZE-1:0]  tap_q [ORDER];
  logic [OPSIZE-1:0]  tap_d [ORDER];
  logic               accept;
  logic               lastSlice;
  logic               running;
  logic [AW-1:0]      addrRun;

  assign running   = (state_q == S_RUN);
  assign lastSlice = (slice_q == SLICE_W'(NSLICE - 1));
  // Flush has priority, so it masks ready and the colliding sample is never taken.
  assign o_ready   = (state_q == S_IDLE) && !i_flush && i_rst_n;
  assign accept    = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          for (int i = 0; i < ORDER; i++) tap_d[i] = '0;
        end else if (accept) begin
          tap_d[0] = i_x;
          for (int i = 1; i < ORDER; i++) tap_d[i] = tap_q[i-1];
          state_d = S_RUN;
          slice_d = '0;
        end
      end
      S_RUN: begin
        if (lastSlice) begin
          state_d = S_DONE;
          slice_d = '0;
        end else begin
          slice_d = slice_q + SLICE_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      slice_q <= '0;
      for (int i = 0; i < ORDER; i++) tap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      for (int i = 0; i < ORDER; i++) tap_q[i] <= tap_d[i];
    end
  end

  // Each ROM partition sees one bit from each of its taps; slice k selects bits k*BAAT+j.
  for (genvar p = 0; p < PARTITION; p++) begin : gen_part
    for (genvar j = 0; j < BAAT; j++) begin : gen_bit
      logic [BIT_W-1:0] bitIdx;
      assign bitIdx = BIT_W'(int'(slice_q) * BAAT + j);
      for (genvar m = 0; m < ADDR_W; m++) begin : gen_addr
        assign addrRun[(p*BAAT+j)*ADDR_W + m] = tap_q[p*ADDR_W + m][bitIdx];
      end
    end
  end

  assign o_rom_addr   = running ? addrRun : '0;
  assign o_acc_en     = running;
  assign o_acc_clr    = running && (slice_q == '0);
  assign o_sign_slice = running && lastSlice;
  assign o_slice      = running ? slice_q : '0;
  assign o_done       = (state_q == S_DONE);
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_da_fir_ctrl.sv
// Self-checking bench for da_fir_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic, all compared each cycle against a tap-list model.
module tb_da_fir_ctrl;

  localparam int OPSIZE    = 12;
  localparam int ORDER     = 6;
  localparam int BAAT      = 3;
  localparam int PARTITION = 2;
  localparam int NSLICE    = OPSIZE / BAAT;
  localparam int ADDR_W    = ORDER / PARTITION;
  localparam int AW        = PARTITION * BAAT * ADDR_W;
  localparam int SLICE_W   = $clog2(NSLICE);

  logic               clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic [OPSIZE-1:0]  i_x = '0;
  logic               i_flush = 1'b0;
  logic               o_ready;
  logic [AW-1:0]      o_rom_addr;
  logic               o_acc_en;
  logic               o_acc_clr;
  logic               o_sign_slice;
  logic [SLICE_W-1:0] o_slice;
  logic               o_done;
  logic               o_busy;

  always #5 clk = ~clk;

  da_fir_ctrl #(
    .OPSIZE(OPSIZE), .ORDER(ORDER), .BAAT(BAAT), .PARTITION(PARTITION)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_x(i_x),
    .o_ready(o_ready), .i_flush(i_flush), .o_rom_addr(o_rom_addr),
    .o_acc_en(o_acc_en), .o_acc_clr(o_acc_clr), .o_sign_slice(o_sign_slice),
    .o_slice(o_slice), .o_done(o_done), .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the tap list plus the number of cycles since the last accept.
  int mtap [ORDER];
  int cyclesSinceAccept = 0;
  logic checkEn = 1'b0;

  initial foreach (mtap[i]) mtap[i] = 0;

  always @(posedge clk) begin
    if (!i_rst_n) begin
      cyclesSinceAccept = 0;
      foreach (mtap[i]) mtap[i] = 0;
    end else if (cyclesSinceAccept == 0) begin
      if (i_flush) begin
        foreach (mtap[i]) mtap[i] = 0;
      end else if (i_valid) begin
        for (int i = ORDER - 1; i > 0; i--) mtap[i] = mtap[i-1];
        mtap[0] = int'(i_x);
        cyclesSinceAccept = 1;
      end
    end else if (cyclesSinceAccept == NSLICE + 1) begin
      cyclesSinceAccept = 0;
    end else begin
      cyclesSinceAccept++;
    end
  end

  function automatic logic [AW-1:0] modelAddr(input int k);
    logic [AW-1:0] r = '0;
    for (int p = 0; p < PARTITION; p++)
      for (int j = 0; j < BAAT; j++)
        for (int m = 0; m < ADDR_W; m++)
          r[(p*BAAT+j)*ADDR_W + m] = ((mtap[p*ADDR_W + m] >> (k*BAAT + j)) & 1) != 0;
    return r;
  endfunction

  logic mRun;
  int   mSlice;

  always @(negedge clk) begin
    if (checkEn) begin
      mRun   = (cyclesSinceAccept >= 1) && (cyclesSinceAccept <= NSLICE);
      mSlice = mRun ? cyclesSinceAccept - 1 : 0;
      checkOutput("ready", 32'(o_ready), 32'((cyclesSinceAccept == 0) && !i_flush && i_rst_n));
      checkOutput("busy", 32'(o_busy), 32'(cyclesSinceAccept != 0));
      checkOutput("done", 32'(o_done), 32'(cyclesSinceAccept == NSLICE + 1));
      checkOutput("acc_en", 32'(o_acc_en), 32'(mRun));
      checkOutput("acc_clr", 32'(o_acc_clr), 32'(mRun && mSlice == 0));
      checkOutput("sign_slice", 32'(o_sign_slice), 32'(mRun && mSlice == NSLICE - 1));
      checkOutput("slice", 32'(o_slice), 32'(mSlice));
      checkOutput("rom_addr", 32'(o_rom_addr), 32'(mRun ? modelAddr(mSlice) : '0));
    end
  end

  typedef struct {
    logic                       flushFirst;
    logic [OPSIZE-1:0]          x;
    logic [NSLICE-1:0][AW-1:0]  addr;
  } vec_t;

  function automatic vec_t mkVec(input logic fl, input logic [OPSIZE-1:0] x,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    vec_t v;
    v.flushFirst = fl;
    v.x          = x;
    v.addr       = {a3, a2, a1, a0};
    return v;
  endfunction

  task automatic applyStimulus(input logic [OPSIZE-1:0] x, input logic chk,
                               input logic [NSLICE-1:0][AW-1:0] addr);
    int waitCnt = 0;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_x     = x;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      waitCnt++;
      if (waitCnt > 20) begin
        checkOutput("acceptTimeout", 32'(0), 32'(1));
        i_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < NSLICE; k++) begin
      @(negedge clk);
      if (chk) checkOutput($sformatf("vecAddr x=%0h k=%0d", x, k), 32'(o_rom_addr), 32'(addr[k]));
    end
    @(negedge clk);
    checkOutput("vecDone", 32'(o_done), 32'(1));
    @(negedge clk);
    checkOutput("vecReadyAfter6", 32'(o_ready), 32'(1));
  endtask

  task automatic doFlush();
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  vec_t vecs [10];
  logic [NSLICE-1:0][AW-1:0] zeroAddr;
  logic [NSLICE-1:0][AW-1:0] orderAddr;
  int   lastAcc, nAcc;
  logic acc;

  initial begin
    vecs[0] = mkVec(1'b0, 12'hFFF, 18'h00049, 18'h00049, 18'h00049, 18'h00049);
    vecs[1] = mkVec(1'b1, 12'h001, 18'h00001, 18'h0, 18'h0, 18'h0);
    vecs[2] = mkVec(1'b0, 12'h000, 18'h00002, 18'h0, 18'h0, 18'h0);
    vecs[3] = mkVec(1'b0, 12'h000, 18'h00004, 18'h0, 18'h0, 18'h0);
    vecs[4] = mkVec(1'b0, 12'h000, 18'h00200, 18'h0, 18'h0, 18'h0);
    vecs[5] = mkVec(1'b0, 12'h000, 18'h00400, 18'h0, 18'h0, 18'h0);
    vecs[6] = mkVec(1'b0, 12'h000, 18'h00800, 18'h0, 18'h0, 18'h0);
    vecs[7] = mkVec(1'b0, 12'h000, 18'h0, 18'h0, 18'h0, 18'h0);
    vecs[8] = mkVec(1'b0, 12'hFFF, 18'h00049, 18'h00049, 18'h00049, 18'h00049);
    vecs[9] = mkVec(1'b0, 12'h800, 18'h00092, 18'h00092, 18'h00092, 18'h000D2);
    zeroAddr  = '0;
    orderAddr = {18'h0, 18'h0, 18'h07030, 18'h0E594};

    // Reset held for three edges, then released.
    @(posedge clk); #1;
    checkEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("resetReady", 32'(o_ready), 32'(0));
      @(posedge clk); #1;
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postResetReady", 32'(o_ready), 32'(1));
    checkOutput("postResetAddr", 32'(o_rom_addr), 32'(0));

    foreach (vecs[i]) begin
      if (vecs[i].flushFirst) doFlush();
      applyStimulus(vecs[i].x, 1'b1, vecs[i].addr);
    end

    // Backpressure: valid held high, one accept every NSLICE+2 cycles.
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_x     = 12'h010;
    lastAcc = -1;
    nAcc    = 0;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(negedge clk);
      acc = o_ready;
      if (acc) begin
        if (lastAcc >= 0) checkOutput("acceptGap", 32'(cyc - lastAcc), 32'(NSLICE + 2));
        lastAcc = cyc;
        nAcc++;
      end
      @(posedge clk); #1;
      if (acc) i_x = i_x + 1'b1;
    end
    i_valid = 1'b0;
    checkOutput("acceptCount", 32'(nAcc), 32'(7));
    applyStimulus(12'h000, 1'b1, orderAddr);

    // Flush collides with valid: the sample must be dropped.
    for (int i = 0; i < ORDER; i++) applyStimulus(12'hFFF, 1'b0, zeroAddr);
    @(posedge clk); #1;
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_x     = 12'h123;
    @(negedge clk);
    checkOutput("flushBlocksReady", 32'(o_ready), 32'(0));
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    checkOutput("flushNoBusy", 32'(o_busy), 32'(0));
    applyStimulus(12'h000, 1'b1, zeroAddr);

    // Reset taken during slice 2.
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_x     = 12'hFFF;
    @(negedge clk);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRunSlice", 32'(o_slice), 32'(2));
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midRunBusy", 32'(o_busy), 32'(0));
    checkOutput("midRunDone", 32'(o_done), 32'(0));
    checkOutput("midRunAccEn", 32'(o_acc_en), 32'(0));
    applyStimulus(12'hFFF, 1'b1, vecs[0].addr);

    // Randomized traffic, checked by the model every cycle.
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      i_valid = ($urandom % 2) == 0;
      i_x     = OPSIZE'($urandom);
      i_flush = ($urandom % 8) == 0;
      i_rst_n = ($urandom % 40) != 0;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
